// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle sequencer.
//   mc_state_e : FSM state encoding, also exported on the core's state port
//   InstW      : instruction width
//   PcInc      : sequential PC increment in bytes
package mc_pkg;

  localparam int unsigned InstW = 32;
  localparam int unsigned PcInc = 4;

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StExe = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4,
    StErr = 3'd7
  } mc_state_e;

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating wait counter used as the handshake watchdog.
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : zero the count (wins over enable)
//   enable      : one more cycle spent waiting
//   expired     : this waiting cycle is the WAIT_MAX-th in a row; constant 0 when WAIT_MAX == 0
module mc_wait_timer #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

  logic [CntW-1:0] cnt_q;

  // Combinational so that an ack arriving in the firing cycle can still win in the FSM.
  assign expired = (WAIT_MAX != 0) && enable && (cnt_q == CntW'(WAIT_MAX - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CntW'(WAIT_MAX))) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/mc_core_seq.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer.
//   clk, resetn            : clock, asynchronous active-low reset
//   inst_req/addr/ack/rdata: instruction SRAM handshake (req held until ack)
//   ir, pc                 : latched instruction and its PC
//   dec_load/store/gr_we   : decoder outputs, sampled in ID
//   br_taken, br_target    : branch resolution, sampled in EXE
//   data_req/we/ack        : data SRAM handshake (req held until ack)
//   rf_we                  : regfile write strobe, WB only
//   state, err             : FSM state and sticky watchdog error
//   debug_wb_pc            : pc during WB, else 0
//   cycle_cnt, retire_cnt  : wrapping performance counters
module mc_core_seq
  import mc_pkg::*;
#(
  parameter int unsigned          PC_W     = 32,
  parameter logic [PC_W-1:0]      RESET_PC = PC_W'(32'h1c000000),
  parameter bit                   SKIP_MEM = 1'b1,
  parameter int unsigned          WAIT_MAX = 16,
  parameter int unsigned          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             inst_req,
  output logic [PC_W-1:0]  inst_addr,
  input  logic             inst_ack,
  input  logic [InstW-1:0] inst_rdata,
  output logic [InstW-1:0] ir,
  output logic [PC_W-1:0]  pc,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_gr_we,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  output logic             data_req,
  output logic             data_we,
  input  logic             data_ack,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic             err,
  output logic [PC_W-1:0]  debug_wb_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  mc_state_e        state_q;
  logic [PC_W-1:0]  pc_q;
  logic [InstW-1:0] ir_q;
  logic             load_q, store_q, gr_we_q;
  logic             br_taken_q;
  logic [PC_W-1:0]  br_target_q;
  logic             err_q;
  logic             started_q;
  logic [CNT_W-1:0] cycle_cnt_q, retire_cnt_q;

  logic mem_access;
  logic wd_enable;
  logic wd_expired;

  assign mem_access = load_q | store_q;

  // Requests are decoded from registered state, so reset drops them immediately.
  assign inst_req    = (state_q == StIf) & started_q;
  assign inst_addr   = pc_q;
  assign data_req    = (state_q == StMem) & mem_access;
  assign data_we     = data_req & store_q;
  assign rf_we       = (state_q == StWb) & gr_we_q;
  assign debug_wb_pc = (state_q == StWb) ? pc_q : '0;
  assign ir          = ir_q;
  assign pc          = pc_q;
  assign state       = state_q;
  assign err         = err_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign retire_cnt  = retire_cnt_q;

  // Any cycle without a pending-and-unacked request (ack, or leaving IF/MEM) restarts the count.
  assign wd_enable = (inst_req & ~inst_ack) | (data_req & ~data_ack);

  mc_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (~wd_enable),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIf;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      load_q       <= 1'b0;
      store_q      <= 1'b0;
      gr_we_q      <= 1'b0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
      err_q        <= 1'b0;
      started_q    <= 1'b0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      started_q <= 1'b1;
      if (started_q) begin
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      end

      case (state_q)
        StIf: begin
          if (inst_req && inst_ack) begin
            ir_q    <= inst_rdata;
            state_q <= StId;
          end else if (wd_expired) begin
            state_q <= StErr;
            err_q   <= 1'b1;
          end
        end
        StId: begin
          load_q  <= dec_load;
          store_q <= dec_store;
          gr_we_q <= dec_gr_we;
          state_q <= StExe;
        end
        StExe: begin
          br_taken_q  <= br_taken;
          br_target_q <= br_target;
          if (mem_access || !SKIP_MEM) begin
            state_q <= StMem;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          // Ack is checked before the watchdog so a last-moment ack is honoured.
          if (!mem_access || data_ack) begin
            state_q <= StWb;
          end else if (wd_expired) begin
            state_q <= StErr;
            err_q   <= 1'b1;
          end
        end
        StWb: begin
          retire_cnt_q <= retire_cnt_q + CNT_W'(1);
          pc_q         <= br_taken_q ? br_target_q : pc_q + PC_W'(PcInc);
          state_q      <= StIf;
        end
        StErr: begin
          state_q <= StErr;
        end
        default: begin
          // Unused encodings fall into the terminal error state.
          state_q <= StErr;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_core_seq.sv
module tb_mc_core_seq;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        inst_ack = 1'b0, dec_load = 1'b0, dec_store = 1'b0, dec_gr_we = 1'b0;
  logic        br_taken = 1'b0, data_ack = 1'b0;
  logic [31:0] inst_rdata = '0, br_target = '0;

  // Instance 0: defaults (SKIP_MEM=1, WAIT_MAX=16); instance 1: SKIP_MEM=0, WAIT_MAX=4.
  logic [1:0]  inst_req_w, data_req_w, data_we_w, rf_we_w, err_w;
  logic [31:0] inst_addr_w [2];
  logic [31:0] ir_w [2];
  logic [31:0] pc_w [2];
  logic [31:0] dbg_w [2];
  logic [31:0] cyc_w [2];
  logic [31:0] ret_w [2];
  logic [2:0]  state_w [2];

  mc_core_seq u_dut0 (
    .clk(clk), .resetn(resetn), .inst_req(inst_req_w[0]), .inst_addr(inst_addr_w[0]),
    .inst_ack(inst_ack), .inst_rdata(inst_rdata), .ir(ir_w[0]), .pc(pc_w[0]),
    .dec_load(dec_load), .dec_store(dec_store), .dec_gr_we(dec_gr_we),
    .br_taken(br_taken), .br_target(br_target), .data_req(data_req_w[0]),
    .data_we(data_we_w[0]), .data_ack(data_ack), .rf_we(rf_we_w[0]), .state(state_w[0]),
    .err(err_w[0]), .debug_wb_pc(dbg_w[0]), .cycle_cnt(cyc_w[0]), .retire_cnt(ret_w[0])
  );

  mc_core_seq #(
    .SKIP_MEM(1'b0),
    .WAIT_MAX(4)
  ) u_dut1 (
    .clk(clk), .resetn(resetn), .inst_req(inst_req_w[1]), .inst_addr(inst_addr_w[1]),
    .inst_ack(inst_ack), .inst_rdata(inst_rdata), .ir(ir_w[1]), .pc(pc_w[1]),
    .dec_load(dec_load), .dec_store(dec_store), .dec_gr_we(dec_gr_we),
    .br_taken(br_taken), .br_target(br_target), .data_req(data_req_w[1]),
    .data_we(data_we_w[1]), .data_ack(data_ack), .rf_we(rf_we_w[1]), .state(state_w[1]),
    .err(err_w[1]), .debug_wb_pc(dbg_w[1]), .cycle_cnt(cyc_w[1]), .retire_cnt(ret_w[1])
  );

  logic        sel = 1'b0;
  logic        o_inst_req, o_data_req, o_data_we, o_rf_we, o_err;
  logic [31:0] o_inst_addr, o_ir, o_pc, o_dbg, o_cyc, o_ret;
  logic [2:0]  o_state;

  always_comb begin
    o_inst_req  = inst_req_w[sel];
    o_data_req  = data_req_w[sel];
    o_data_we   = data_we_w[sel];
    o_rf_we     = rf_we_w[sel];
    o_err       = err_w[sel];
    o_inst_addr = inst_addr_w[sel];
    o_ir        = ir_w[sel];
    o_pc        = pc_w[sel];
    o_dbg       = dbg_w[sel];
    o_cyc       = cyc_w[sel];
    o_ret       = ret_w[sel];
    o_state     = state_w[sel];
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural PC, retired count, cycles since start.
  logic [31:0] m_pc;
  int          m_ret;
  int          m_cyc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset(input logic which);
    sel = which;
    resetn = 1'b0;
    inst_ack = 1'b0;
    data_ack = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    m_pc = RST_PC;
    m_ret = 0;
    m_cyc = 0;
  endtask

  // One instruction: fdel fetch wait cycles, mdel data wait cycles. Phases follow the
  // instruction's architectural timeline; 0=IF 1=ID 2=EXE 3=MEM 4=WB.
  task automatic run_instr(input bit ld, input bit st, input bit gwe, input bit tk,
                           input logic [31:0] tgt, input int fdel, input int mdel);
    int memc, total, ph;
    logic [31:0] word, nxt;
    memc = (ld || st) ? mdel + 1 : (sel ? 1 : 0);
    total = fdel + 1 + 2 + memc + 1;
    word = $urandom;
    inst_rdata = word;
    nxt = tk ? tgt : m_pc + 32'd4;
    for (int i = 0; i < total; i++) begin
      if (i <= fdel) ph = 0;
      else if (i == fdel + 1) ph = 1;
      else if (i == fdel + 2) ph = 2;
      else if (i < fdel + 3 + memc) ph = 3;
      else ph = 4;
      // Acks outside their request window are random noise that must be ignored.
      inst_ack  = (i == fdel) ? 1'b1 : ((i > fdel) ? 1'($urandom) : 1'b0);
      dec_load  = (ph == 1) ? ld : 1'($urandom);
      dec_store = (ph == 1) ? st : 1'($urandom);
      dec_gr_we = (ph == 1) ? gwe : 1'($urandom);
      br_taken  = (ph == 2) ? tk : 1'($urandom);
      br_target = (ph == 2) ? tgt : $urandom;
      if (ph == 3 && (ld || st)) data_ack = (i == fdel + 3 + mdel);
      else data_ack = 1'($urandom);

      n_tests++;
      if (o_state !== 3'(ph)) begin
        n_fail++;
        $display("FAIL state: cycle %0d got %0d expected %0d", i, o_state, ph);
      end
      n_tests++;
      if (o_inst_req !== (ph == 0)) begin
        n_fail++;
        $display("FAIL inst_req: cycle %0d got %b expected %b", i, o_inst_req, ph == 0);
      end
      n_tests++;
      if (o_rf_we !== (ph == 4 && gwe)) begin
        n_fail++;
        $display("FAIL rf_we: cycle %0d got %b expected %b", i, o_rf_we, ph == 4 && gwe);
      end
      n_tests++;
      if (o_data_req !== (ph == 3 && (ld || st))) begin
        n_fail++;
        $display("FAIL data_req: cycle %0d got %b expected %b", i, o_data_req,
                 ph == 3 && (ld || st));
      end
      n_tests++;
      if (o_data_we !== (ph == 3 && st)) begin
        n_fail++;
        $display("FAIL data_we: cycle %0d got %b expected %b", i, o_data_we, ph == 3 && st);
      end
      n_tests++;
      if (o_dbg !== ((ph == 4) ? m_pc : 32'h0)) begin
        n_fail++;
        $display("FAIL debug_wb_pc: cycle %0d got %h expected %h", i, o_dbg,
                 (ph == 4) ? m_pc : 32'h0);
      end
      n_tests++;
      if (o_pc !== m_pc) begin
        n_fail++;
        $display("FAIL pc: cycle %0d got %h expected %h", i, o_pc, m_pc);
      end
      if (ph == 1) begin
        n_tests++;
        if (o_ir !== word) begin
          n_fail++;
          $display("FAIL ir: got %h expected %h", o_ir, word);
        end
      end
      @(negedge clk);
    end
    inst_ack = 1'b0;
    data_ack = 1'b0;
    m_pc = nxt;
    m_ret++;
    m_cyc += total;
    n_tests++;
    if (o_inst_addr !== m_pc || o_state !== 3'd0) begin
      n_fail++;
      $display("FAIL next_fetch: got addr %h state %0d expected addr %h state 0",
               o_inst_addr, o_state, m_pc);
    end
    n_tests++;
    if (o_ret !== 32'(m_ret)) begin
      n_fail++;
      $display("FAIL retire_cnt: got %0d expected %0d", o_ret, m_ret);
    end
    n_tests++;
    if (o_cyc !== 32'(m_cyc)) begin
      n_fail++;
      $display("FAIL cycle_cnt: got %0d expected %0d", o_cyc, m_cyc);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (o_state !== 3'd0 || o_pc !== RST_PC || o_inst_addr !== RST_PC || o_ir !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got state %0d pc %h addr %h ir %h expected 0 %h %h 0",
               o_state, o_pc, o_inst_addr, o_ir, RST_PC, RST_PC);
    end
    n_tests++;
    if ({o_inst_req, o_data_req, o_data_we, o_rf_we, o_err} !== 5'b0 || o_dbg !== 32'h0 ||
        o_cyc !== 32'h0 || o_ret !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outs: got req/dreq/we/rfwe/err %b dbg %h cyc %0d ret %0d expected 0",
               {o_inst_req, o_data_req, o_data_we, o_rf_we, o_err}, o_dbg, o_cyc, o_ret);
    end
    resetn = 1'b1;
    #1;
    n_tests++;
    if (o_inst_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_before_start: got %b expected 0", o_inst_req);
    end
    @(negedge clk);
    n_tests++;
    if (o_inst_req !== 1'b1 || o_cyc !== 32'h0) begin
      n_fail++;
      $display("FAIL first_req: got req %b cyc %0d expected req 1 cyc 0", o_inst_req, o_cyc);
    end
    m_pc = RST_PC;
    m_ret = 0;
    m_cyc = 0;
  endtask

  task automatic test_alu();
    do_reset(1'b0);
    run_instr(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2, 0);
  endtask

  task automatic test_load();
    run_instr(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0, 3);
  endtask

  task automatic test_store_branch();
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 2);
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h1c000100, 0, 0);
    n_tests++;
    if (o_inst_addr !== 32'h1c000100) begin
      n_fail++;
      $display("FAIL branch_target: got %h expected 1c000100", o_inst_addr);
    end
    // Branch to the current pc.
    run_instr(1'b0, 1'b0, 1'b1, 1'b1, m_pc, 1, 0);
  endtask

  task automatic run_random(input int n, input int maxdel);
    logic [31:0] tgt;
    bit ld, st;
    for (int k = 0; k < n; k++) begin
      ld = ($urandom_range(0, 2) == 0);
      st = !ld && ($urandom_range(0, 2) == 0);
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) tgt = m_pc;
      run_instr(ld, st, 1'($urandom), 1'($urandom), tgt,
                $urandom_range(0, maxdel), $urandom_range(0, maxdel));
    end
  endtask

  task automatic test_random();
    run_random(25, 5);
  endtask

  task automatic test_no_skip();
    do_reset(1'b1);
    run_instr(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
    // Fetch ack lands in the cycle the watchdog would otherwise fire.
    run_instr(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 3, 0);
    run_instr(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0, 3);
    run_random(10, 3);
  endtask

  task automatic test_watchdog();
    do_reset(1'b1);
    inst_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (o_state !== 3'd0 || o_err !== 1'b0 || o_inst_req !== 1'b1) begin
        n_fail++;
        $display("FAIL wd_wait: cycle %0d got state %0d err %b req %b expected 0 0 1",
                 k, o_state, o_err, o_inst_req);
      end
      @(negedge clk);
    end
    n_tests++;
    if (o_state !== 3'd7 || o_err !== 1'b1 || o_inst_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_fire: got state %0d err %b req %b expected 7 1 0",
               o_state, o_err, o_inst_req);
    end
    for (int k = 0; k < 5; k++) begin
      inst_ack = 1'($urandom);
      data_ack = 1'($urandom);
      inst_rdata = $urandom;
      @(negedge clk);
    end
    n_tests++;
    if (o_state !== 3'd7 || o_err !== 1'b1 || {o_inst_req, o_data_req, o_data_we, o_rf_we} !==
        4'b0 || o_pc !== RST_PC || o_ir !== 32'h0) begin
      n_fail++;
      $display("FAIL err_hold: got state %0d err %b reqs %b pc %h ir %h expected 7 1 0 %h 0",
               o_state, o_err, {o_inst_req, o_data_req, o_data_we, o_rf_we}, o_pc, o_ir,
               RST_PC);
    end
    n_tests++;
    if (o_cyc !== 32'd9) begin
      n_fail++;
      $display("FAIL err_cycle_cnt: got %0d expected 9", o_cyc);
    end
    inst_ack = 1'b0;
    data_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    run_instr(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
    inst_ack = 1'b1;
    inst_rdata = $urandom;
    @(negedge clk);
    inst_ack = 1'b0;
    dec_load = 1'b1;
    dec_store = 1'b0;
    dec_gr_we = 1'b1;
    @(negedge clk);
    br_taken = 1'b0;
    @(negedge clk);
    n_tests++;
    if (o_state !== 3'd3 || o_data_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mem: got state %0d dreq %b expected 3 1", o_state, o_data_req);
    end
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if (o_state !== 3'd0 || o_pc !== RST_PC || o_data_req !== 1'b0 || o_cyc !== 32'h0 ||
        o_ret !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got state %0d pc %h dreq %b cyc %0d ret %0d expected 0 %h 0 0 0",
               o_state, o_pc, o_data_req, o_cyc, o_ret, RST_PC);
    end
    @(negedge clk);
    resetn = 1'b1;
    data_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (o_rf_we !== 1'b0 || o_data_req !== 1'b0 || o_state !== 3'd0 || o_ret !== 32'h0) begin
        n_fail++;
        $display("FAIL stale_ack: cycle %0d got rfwe %b dreq %b state %0d ret %0d expected 0",
                 k, o_rf_we, o_data_req, o_state, o_ret);
      end
    end
    data_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_branch();
    test_random();
    test_no_skip();
    test_watchdog();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_core_seq.md
Name: mc_core_seq

Overview:
- Parametrised multi-cycle sequencer for the LoongArch core.
- Replaces the single-cycle "every stage in one clock" flow with an IF/ID/EXE/MEM/WB state machine.
- Owns the PC and instruction register, runs req/ack handshakes to instruction and data SRAM, and gates regfile/memory write enables to exactly one cycle per instruction.
- Provides trace and performance counters.

Parameters:
- PC_W, 32, PC and address width.
- RESET_PC, 32'h1c000000, first fetch address.
- SKIP_MEM, 1, 1: non-load/store instructions go EXE->WB; 0: every instruction visits MEM without issuing data_req.
- WAIT_MAX, 16, max cycles waiting for an ack before error; 0 disables the watchdog.
- CNT_W, 32, width of the perf counters.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  out  1  fetch request, held until acked
- inst_addr  out  PC_W  fetch address (= pc)
- inst_ack  in  1  fetch data valid this cycle
- inst_rdata  in  32  fetched instruction
- ir  out  32  latched instruction register
- pc  out  PC_W  PC of the instruction in flight
- dec_load  in  1  decoder: load, valid in ID
- dec_store  in  1  decoder: store, valid in ID
- dec_gr_we  in  1  decoder: writes regfile, valid in ID
- br_taken  in  1  branch resolved taken, valid in EXE
- br_target  in  PC_W  branch target, valid in EXE
- data_req  out  1  data SRAM request, held until acked
- data_we  out  1  store qualifier, valid with data_req
- data_ack  in  1  data access complete
- rf_we  out  1  regfile write strobe, single WB cycle
- state  out  3  IF=0 ID=1 EXE=2 MEM=3 WB=4 ERR=7
- err  out  1  sticky watchdog error
- debug_wb_pc  out  PC_W  pc during WB, else 0
- cycle_cnt  out  CNT_W  cycles since reset
- retire_cnt  out  CNT_W  instructions retired

Behaviour:
- Reset (resetn low, async):
  - state=IF, pc=RESET_PC, ir=0, decode flags=0, err=0, counters=0, wait counter=0.
  - "started" flag=0; all outputs 0 except pc and inst_addr.
- Start: started sets on the first clk edge after resetn rises. inst_req = (state==IF) & started, so the first fetch request appears one cycle after deassertion.
- Handshakes:
  - A request stays high until the ack is sampled in the same cycle.
  - An ack with its request low is ignored.
  - Zero-wait (ack in the first req cycle) is legal, giving a 1-cycle IF/MEM.
- IF: on inst_ack, ir<=inst_rdata and go to ID.
- ID: one cycle; latch dec_load, dec_store, dec_gr_we; go to EXE.
- EXE: one cycle; latch br_taken and br_target.
  - If (load|store) or SKIP_MEM==0, go to MEM; else go to WB.
- MEM:
  - data_req = load|store; data_we = store.
  - On data_ack, go to WB. With no access, MEM lasts 1 cycle.
- WB: one cycle.
  - rf_we = gr_we_latched.
  - debug_wb_pc = pc; retire_cnt += 1.
  - pc <= br_taken_latched ? br_target_latched : pc+4 (mod 2^PC_W); go to IF.
- Write-enable guarantee: rf_we and data_we are never high outside WB/MEM respectively, and never high in ERR.
- Watchdog:
  - Counts consecutive cycles in IF or MEM with a pending request and no ack; clears on ack and on state change.
  - When it reaches WAIT_MAX (WAIT_MAX>0): go to ERR, set err, drop all requests.
  - ERR is terminal until reset; pc and ir are frozen; cycle_cnt keeps counting.
- Counters: cycle_cnt increments every cycle once started. Both counters wrap to 0 at 2^CNT_W.
- Edge cases:
  - Reset mid-handshake aborts immediately; any later ack is ignored until the next req.
  - An ack arriving in the cycle the watchdog fires is honoured (ack wins).
  - A branch to the current pc is legal.

Decomposition:
- Shared package mc_pkg: state encodings (IF..WB, ERR), instruction width 32, PC increment constant 4.
- One sub-module, mc_wait_timer (WAIT_MAX-parameterised saturating counter with clear/enable/expired), instantiated once.
- The FSM, PC/IR and perf counters stay in mc_core_seq.

Test Plan:
1. Reset release, inst_ack tied high, add.w with gr_we=1: inst_addr=0x1c000000; state sequence IF,ID,EXE,WB; rf_we high 1 cycle; next inst_addr=0x1c000004; retire_cnt=1 after 4 cycles.
2. Load with data_ack delayed 3 cycles: data_req high 4 cycles, data_we=0; rf_we in WB; 8 cycles per instruction with zero-wait fetch.
3. Store, then beq with br_taken=1, br_target=0x1c000100: data_we=1 only with data_req; rf_we stays 0; after the beq WB, inst_addr=0x1c000100.
4. SKIP_MEM=0 with ALU ops: every instruction takes 5 cycles; data_req never asserted.
5. WAIT_MAX=4, inst_ack held low: state=ERR and err=1 on the 4th waiting cycle; inst_req=0 thereafter; ack in that same cycle instead moves to ID.
6. resetn pulsed low during MEM of a load: state=IF and pc=0x1c000000 immediately; a stale data_ack produces no rf_we; counters=0.
